// File: rtl/ddr_ca_delay_ctrl_if.sv
// Command bus between the training/calibration sequencer and the CA delay-line controller.
//   cmd_valid / cmd_ready : request / accept handshake
//   cmd_op                : 00 LOAD, 01 INC, 10 DEC, 11 SET
//   cmd_lane / cmd_bcast  : target lane, or all lanes when cmd_bcast is high
//   cmd_value             : step count (INC/DEC) or absolute target tap (SET)
//   done / cmd_err        : one-cycle completion pulse and its status
interface ddr_ca_delay_ctrl_if #(
  parameter int unsigned LANE_W = 4,
  parameter int unsigned TAP_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [LANE_W-1:0] cmd_lane;
  logic              cmd_bcast;
  logic [TAP_W-1:0]  cmd_value;
  logic              done;
  logic              cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_lane, cmd_bcast, cmd_value,
    input  cmd_ready, done, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_lane, cmd_bcast, cmd_value,
    output cmd_ready, done, cmd_err
  );
endinterface

// File: rtl/ddr_ca_delay_ctrl.sv
// Delay-line controller for the DDR3 address/command IOD lanes.
// Takes one tap command at a time over the cmd bus, sequences LOAD / MOVE / DIRECTION
// pulses to the lane IODs, tracks every lane's tap count and aborts on out-of-range.
//   fab_clk, arst_n          : clock, asynchronous active-low reset
//   cmd                      : command bus (slave side)
//   delay_line_load/move     : per-lane one-cycle pulses, only on the selected lanes
//   delay_line_direction     : per-lane direction, 1 = increment, held between commands
//   delay_line_out_of_range  : per-lane IOD range flag, sampled on the last gap cycle
//   err_lane / err_clr       : sticky per-lane error flags and their clear
//   rd_lane / rd_tap         : registered tap readback
module ddr_ca_delay_ctrl #(
  parameter int unsigned NUM_LANES = 14,
  parameter int unsigned TAP_W     = 8,
  parameter int unsigned MAX_TAP   = 255,
  parameter int unsigned RESET_TAP = 1,
  parameter int unsigned MOVE_GAP  = 4,
  localparam int unsigned LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 fab_clk,
  input  logic                 arst_n,
  ddr_ca_delay_ctrl_if.slave   cmd,
  output logic [NUM_LANES-1:0] delay_line_load,
  output logic [NUM_LANES-1:0] delay_line_move,
  output logic [NUM_LANES-1:0] delay_line_direction,
  input  logic [NUM_LANES-1:0] delay_line_out_of_range,
  output logic [NUM_LANES-1:0] err_lane,
  input  logic                 err_clr,
  input  logic [LANE_W-1:0]    rd_lane,
  output logic [TAP_W-1:0]     rd_tap
);

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpInc  = 2'b01;
  localparam logic [1:0] OpDec  = 2'b10;
  localparam logic [1:0] OpSet  = 2'b11;

  typedef enum logic [2:0] {StIdle, StLoad, StSetup, StMove, StGap, StFin} state_e;

  state_e               state_q, state_d;
  logic [NUM_LANES-1:0] mask_q, mask_d;
  logic                 inc_q, inc_d;
  logic [TAP_W-1:0]     rem_q, rem_d;
  logic [3:0]           gap_q, gap_d;
  logic                 err_q, err_d;
  logic [NUM_LANES-1:0] dir_q, dir_d;
  logic [NUM_LANES-1:0] err_lane_q;
  logic [TAP_W-1:0]     rd_tap_q;
  logic [TAP_W-1:0]     tap_q [NUM_LANES];

  logic [NUM_LANES-1:0] acc_mask;
  logic [NUM_LANES-1:0] limit_hit;
  logic [NUM_LANES-1:0] oor_hit;
  logic [NUM_LANES-1:0] err_set;
  logic [TAP_W-1:0]     cur_tap;
  logic [TAP_W-1:0]     rd_sel;
  logic                 lane_ok;

  // Lane decode, tracked-count lookups and the pre-move limit check.
  always_comb begin
    acc_mask  = '0;
    limit_hit = '0;
    cur_tap   = '0;
    rd_sel    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (cmd.cmd_bcast || (cmd.cmd_lane == LANE_W'(i))) acc_mask[i] = 1'b1;
      if (cmd.cmd_lane == LANE_W'(i)) cur_tap = tap_q[i];
      if (rd_lane == LANE_W'(i)) rd_sel = tap_q[i];
      if (mask_q[i] && (inc_q ? (tap_q[i] == TAP_W'(MAX_TAP)) : (tap_q[i] == '0))) begin
        limit_hit[i] = 1'b1;
      end
    end
    lane_ok = cmd.cmd_bcast || (32'(cmd.cmd_lane) < NUM_LANES);
    oor_hit = mask_q & delay_line_out_of_range;
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    inc_d   = inc_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    err_d   = err_q;
    dir_d   = dir_q;
    err_set = '0;
    unique case (state_q)
      StIdle: begin
        if (cmd.cmd_valid) begin
          mask_d = acc_mask;
          err_d  = 1'b0;
          if (!lane_ok) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            unique case (cmd.cmd_op)
              OpLoad: state_d = StLoad;
              OpInc, OpDec: begin
                inc_d = (cmd.cmd_op == OpInc);
                rem_d = cmd.cmd_value;
                if (cmd.cmd_value == '0) begin
                  state_d = StFin;
                end else begin
                  state_d = StSetup;
                  dir_d   = (dir_q & ~acc_mask) | ((cmd.cmd_op == OpInc) ? acc_mask : '0);
                end
              end
              OpSet: begin
                if (cmd.cmd_bcast || (32'(cmd.cmd_value) > MAX_TAP)) begin
                  err_d   = 1'b1;
                  state_d = StFin;
                end else if (cmd.cmd_value == cur_tap) begin
                  state_d = StFin;
                end else begin
                  // SET becomes a relative move of |target - current| steps.
                  inc_d   = (cmd.cmd_value > cur_tap);
                  rem_d   = (cmd.cmd_value > cur_tap) ? (cmd.cmd_value - cur_tap)
                                                      : (cur_tap - cmd.cmd_value);
                  dir_d   = (dir_q & ~acc_mask) | ((cmd.cmd_value > cur_tap) ? acc_mask : '0);
                  state_d = StSetup;
                end
              end
              default: state_d = StFin;
            endcase
          end
        end
      end
      StLoad: state_d = StFin;
      StSetup: begin
        if (|limit_hit) begin
          err_set = limit_hit;
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          state_d = StMove;
        end
      end
      StMove: begin
        rem_d   = rem_q - TAP_W'(1);
        gap_d   = 4'(MOVE_GAP - 1);
        state_d = StGap;
      end
      StGap: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 4'd1;
        end else if (|oor_hit) begin
          // The IOD flag is only trusted once the delay line has settled.
          err_set = oor_hit;
          err_d   = 1'b1;
          state_d = StFin;
        end else if (rem_q == '0) begin
          state_d = StFin;
        end else if (|limit_hit) begin
          err_set = limit_hit;
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          state_d = StMove;
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      inc_q      <= 1'b0;
      rem_q      <= '0;
      gap_q      <= '0;
      err_q      <= 1'b0;
      dir_q      <= '0;
      err_lane_q <= '0;
      rd_tap_q   <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      inc_q      <= inc_d;
      rem_q      <= rem_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
      dir_q      <= dir_d;
      // A new error outranks a simultaneous clear.
      err_lane_q <= (err_lane_q & ~{NUM_LANES{err_clr}}) | err_set;
      rd_tap_q   <= rd_sel;
    end
  end

  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= TAP_W'(RESET_TAP);
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (mask_q[i] && (state_q == StLoad)) begin
          tap_q[i] <= TAP_W'(RESET_TAP);
        end else if (mask_q[i] && (state_q == StMove)) begin
          tap_q[i] <= inc_q ? (tap_q[i] + TAP_W'(1)) : (tap_q[i] - TAP_W'(1));
        end
      end
    end
  end

  assign cmd.cmd_ready         = (state_q == StIdle);
  assign cmd.done              = (state_q == StFin);
  assign cmd.cmd_err           = (state_q == StFin) && err_q;
  assign delay_line_load       = (state_q == StLoad) ? mask_q : '0;
  assign delay_line_move       = (state_q == StMove) ? mask_q : '0;
  assign delay_line_direction  = dir_q;
  assign err_lane              = err_lane_q;
  assign rd_tap                = rd_tap_q;

endmodule

// File: tb/tb_ddr_ca_delay_ctrl.sv
module tb_ddr_ca_delay_ctrl;
  localparam int NL   = 14;
  localparam int TW   = 8;
  localparam int LW   = 4;
  localparam int G    = 4;
  localparam int MAXT = 255;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  ddr_ca_delay_ctrl_if #(.LANE_W(LW), .TAP_W(TW)) cmd_bus ();

  logic [NL-1:0] load, move, dir, oor, err_lane;
  logic          err_clr;
  logic [LW-1:0] rd_lane;
  logic [TW-1:0] rd_tap;

  ddr_ca_delay_ctrl #(
    .NUM_LANES(NL), .TAP_W(TW), .MAX_TAP(MAXT), .RESET_TAP(1), .MOVE_GAP(G)
  ) dut (
    .fab_clk                 (clk),
    .arst_n                  (arst_n),
    .cmd                     (cmd_bus),
    .delay_line_load         (load),
    .delay_line_move         (move),
    .delay_line_direction    (dir),
    .delay_line_out_of_range (oor),
    .err_lane                (err_lane),
    .err_clr                 (err_clr),
    .rd_lane                 (rd_lane),
    .rd_tap                  (rd_tap)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-lane tap counts, sticky errors, direction levels.
  int            m_tap [NL];
  logic [NL-1:0] m_err;
  logic [NL-1:0] m_dir;

  typedef struct {
    int op; int lane; int bcast; int value; int oor_after; int clr;
    int exp_err; int exp_lat; int rd_lane; int exp_rd;
  } vec_t;
  vec_t tbl [14];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NL-1:0] lane_mask(input int lane, input int bcast);
    logic [NL-1:0] m;
    m = '0;
    if (bcast != 0) m = '1;
    else if (lane < NL) m[lane] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_tap[i] = 1;
    m_err = '0;
    m_dir = '0;
  endtask

  // Predicts status, DONE latency (cycles after acceptance) and moves issued.
  task automatic model_cmd(input int op, input int lane, input int bcast, input int value,
                           input int oor_after, input logic [NL-1:0] oor_vec, input int clr,
                           output int e_err, output int e_lat, output int e_moves,
                           output int e_loads);
    logic [NL-1:0] mask, set;
    int n;
    bit inc;
    mask = lane_mask(lane, bcast);
    set = '0; e_err = 0; e_moves = 0; e_loads = 0; e_lat = 1;
    if (bcast == 0 && lane >= NL) begin
      e_err = 1;
    end else if (op == 0) begin
      e_lat = 2; e_loads = 1;
      for (int i = 0; i < NL; i++) if (mask[i]) m_tap[i] = 1;
    end else if (op == 3 && bcast != 0) begin
      e_err = 1;
    end else begin
      if (op == 3) begin
        n = value - m_tap[lane];
        inc = (n > 0);
        if (n < 0) n = -n;
      end else begin
        n = value;
        inc = (op == 1);
      end
      if (n > 0) begin
        for (int i = 0; i < NL; i++) if (mask[i]) m_dir[i] = inc;
        e_lat = 2 + n * (G + 1);
        for (int j = 0; j < n; j++) begin
          for (int i = 0; i < NL; i++)
            if (mask[i] && (inc ? m_tap[i] == MAXT : m_tap[i] == 0)) set[i] = 1'b1;
          if (set != 0) begin e_err = 1; e_lat = 2 + j * (G + 1); break; end
          for (int i = 0; i < NL; i++) if (mask[i]) m_tap[i] += inc ? 1 : -1;
          e_moves++;
          if (j == oor_after && (mask & oor_vec) != 0) begin
            set = mask & oor_vec; e_err = 1; e_lat = 2 + (j + 1) * (G + 1); break;
          end
        end
      end
    end
    m_err = (clr != 0) ? set : (m_err | set);
  endtask

  // Issues one command; err_clr is held from before acceptance until DONE when clr is set.
  task automatic run_cmd(input int op, input int lane, input int bcast, input int value,
                         input int oor_after, input logic [NL-1:0] oor_vec, input int clr,
                         output int lat, output int err, output int moves, output int loads,
                         output int leak);
    logic [NL-1:0] mask;
    mask = lane_mask(lane, bcast);
    lat = -1; err = -1; moves = 0; loads = 0; leak = 0;
    @(negedge clk);
    check("ready_before_cmd", longint'(cmd_bus.cmd_ready), 1);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = 2'(op);
    cmd_bus.cmd_lane  = LW'(lane);
    cmd_bus.cmd_bcast = (bcast != 0);
    cmd_bus.cmd_value = TW'(value);
    err_clr           = (clr != 0);
    @(posedge clk);
    #1;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = 2'($urandom);
    cmd_bus.cmd_lane  = LW'($urandom);
    cmd_bus.cmd_bcast = 1'($urandom);
    cmd_bus.cmd_value = TW'($urandom);
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (((move & ~mask) != 0) || ((load & ~mask) != 0)) leak = 1;
      if (move != 0) begin
        moves++;
        if (move != mask) leak = 1;
        if (moves == oor_after + 1) oor = oor_vec;
      end
      if (load != 0) begin
        loads++;
        if (load != mask) leak = 1;
      end
      if (cmd_bus.done) begin
        lat = c;
        err = int'(cmd_bus.cmd_err);
        break;
      end
    end
    oor = '0;
    err_clr = 1'b0;
    if (lat < 0) $display("FAIL done_timeout: got no DONE, want DONE within 3000 cycles");
  endtask

  task automatic readback_all(input string tag);
    rd_lane = '0;
    for (int l = 0; l < 16; l++) begin
      @(negedge clk);
      check($sformatf("%s rd_tap[%0d]", tag, l), longint'(rd_tap), (l < NL) ? m_tap[l] : 0);
      rd_lane = LW'(l + 1);
    end
  endtask

  task automatic read_one(input int lane, output int val);
    @(negedge clk);
    rd_lane = LW'(lane);
    @(negedge clk);
    val = int'(rd_tap);
  endtask

  task automatic do_cmd(input string tag, input int op, input int lane, input int bcast,
                        input int value, input int oor_after, input logic [NL-1:0] oor_vec,
                        input int clr, output int lat, output int err);
    int e_err, e_lat, e_moves, e_loads, moves, loads, leak;
    model_cmd(op, lane, bcast, value, oor_after, oor_vec, clr, e_err, e_lat, e_moves, e_loads);
    run_cmd(op, lane, bcast, value, oor_after, oor_vec, clr, lat, err, moves, loads, leak);
    check({tag, " latency"}, lat, e_lat);
    check({tag, " cmd_err"}, err, e_err);
    check({tag, " moves"}, moves, e_moves);
    check({tag, " loads"}, loads, e_loads);
    check({tag, " unmasked_pulse"}, leak, 0);
    @(negedge clk);
    check({tag, " direction"}, longint'(dir), longint'(m_dir));
    check({tag, " err_lane"}, longint'(err_lane), longint'(m_err));
    readback_all(tag);
  endtask

  initial begin
    int lat, err, rv, op, lane, bcast, value, clr, base, moves_seen;
    bit hit;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = '0;
    cmd_bus.cmd_lane  = '0;
    cmd_bus.cmd_bcast = 1'b0;
    cmd_bus.cmd_value = '0;
    oor = '0; err_clr = 1'b0; rd_lane = '0;
    arst_n = 1'b0;
    model_reset();

    // {op, lane, bcast, value, oor_after, clr, exp_err, exp_lat, rd_lane, exp_rd}
    tbl[0]  = '{2, 0,  1, 2,   -1, 0, 1, 7,    0, 0};
    tbl[1]  = '{0, 0,  1, 0,   -1, 0, 0, 2,    0, 1};
    tbl[2]  = '{1, 3,  0, 3,   -1, 0, 0, 17,   3, 4};
    tbl[3]  = '{3, 5,  0, 10,  -1, 0, 0, 47,   5, 10};
    tbl[4]  = '{3, 5,  1, 7,   -1, 0, 1, 1,    5, 10};
    tbl[5]  = '{1, 2,  0, 5,    1, 0, 1, 12,   2, 3};
    tbl[6]  = '{1, 14, 0, 1,   -1, 0, 1, 1,    0, 1};
    tbl[7]  = '{1, 0,  0, 0,   -1, 0, 0, 1,    0, 1};
    tbl[8]  = '{3, 3,  0, 4,   -1, 0, 0, 1,    3, 4};
    tbl[9]  = '{2, 3,  0, 2,   -1, 0, 0, 12,   3, 2};
    tbl[10] = '{0, 3,  0, 0,   -1, 0, 0, 2,    3, 1};
    tbl[11] = '{3, 5,  0, 8,   -1, 0, 0, 12,   5, 8};
    tbl[12] = '{3, 7,  0, 255, -1, 0, 0, 1272, 7, 255};
    tbl[13] = '{1, 7,  0, 1,   -1, 1, 1, 2,    7, 255};

    // Reset state, checked both during and after reset.
    #12;
    check("reset cmd_ready", longint'(cmd_bus.cmd_ready), 1);
    check("reset done", longint'(cmd_bus.done), 0);
    check("reset cmd_err", longint'(cmd_bus.cmd_err), 0);
    check("reset load", longint'(load), 0);
    check("reset move", longint'(move), 0);
    check("reset direction", longint'(dir), 0);
    check("reset err_lane", longint'(err_lane), 0);
    check("reset rd_tap", longint'(rd_tap), 0);
    @(negedge clk);
    arst_n = 1'b1;
    readback_all("reset");

    for (int t = 0; t < 14; t++) begin
      do_cmd($sformatf("tbl%0d", t), tbl[t].op, tbl[t].lane, tbl[t].bcast, tbl[t].value,
             tbl[t].oor_after, (tbl[t].oor_after >= 0) ? lane_mask(tbl[t].lane, 0) : '0,
             tbl[t].clr, lat, err);
      check($sformatf("tbl%0d hand latency", t), lat, tbl[t].exp_lat);
      check($sformatf("tbl%0d hand cmd_err", t), err, tbl[t].exp_err);
      read_one(tbl[t].rd_lane, rv);
      check($sformatf("tbl%0d hand rd_tap", t), rv, tbl[t].exp_rd);
      if (t == 0) check("bcast dec err_lane", longint'(err_lane), 14'h3fff);
      if (t == 13) check("clr vs set err_lane", longint'(err_lane), 14'h0080);
    end

    // Randomised commands against the model.
    for (int r = 0; r < 40; r++) begin
      op    = $urandom_range(0, 3);
      lane  = $urandom_range(0, 15);
      bcast = ($urandom_range(0, 7) == 0) ? 1 : 0;
      clr   = ($urandom_range(0, 5) == 0) ? 1 : 0;
      if (op == 3) begin
        base  = m_tap[(lane < NL) ? lane : 0] + $urandom_range(0, 12) - 6;
        value = (base < 0) ? 0 : (base > MAXT) ? MAXT : base;
      end else begin
        value = $urandom_range(0, 5);
      end
      do_cmd($sformatf("rnd%0d op%0d lane%0d b%0d v%0d", r, op, lane, bcast, value),
             op, lane, bcast, value, -1, '0, clr, lat, err);
    end

    // Asynchronous reset during the second move of an INC.
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = 2'b01;
    cmd_bus.cmd_lane  = LW'(4);
    cmd_bus.cmd_bcast = 1'b0;
    cmd_bus.cmd_value = TW'(5);
    @(posedge clk);
    #1;
    cmd_bus.cmd_valid = 1'b0;
    moves_seen = 0;
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (move[4]) moves_seen++;
      if (moves_seen == 2) begin hit = 1'b1; break; end
    end
    check("arst reached move 2", hit, 1);
    arst_n = 1'b0;
    #1;
    check("arst move dropped", longint'(move), 0);
    check("arst load low", longint'(load), 0);
    check("arst direction", longint'(dir), 0);
    check("arst done low", longint'(cmd_bus.done), 0);
    check("arst cmd_ready", longint'(cmd_bus.cmd_ready), 1);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    model_reset();
    hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (move != 0 || load != 0 || cmd_bus.done) hit = 1'b1;
    end
    check("arst no later pulses", hit, 0);
    check("arst cmd_ready after", longint'(cmd_bus.cmd_ready), 1);
    readback_all("after_arst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr_ca_delay_ctrl.md
Name: ddr_ca_delay_ctrl

Overview:
- Parametrised delay-line controller for the DDR3 address/command IOD lanes.
- Sits between the training/calibration sequencer and N lane IODs on FAB_CLK.
- Accepts one tap command at a time: load, increment, decrement or set absolute, on one lane or broadcast to all lanes.
- Emits correctly sequenced DELAY_LINE_LOAD/MOVE/DIRECTION pulses, tracks each lane's tap count, and aborts on out-of-range.

Parameters:
- NUM_LANES, 14, number of controlled IOD lanes (1..32).
- TAP_W, 8, tap counter width.
- MAX_TAP, 255, highest legal tap value (must be less than 2^TAP_W).
- RESET_TAP, 1, tap value after reset or LOAD; matches the IOD static TX delay.
- MOVE_GAP, 4, idle cycles after each MOVE pulse (1..15).
- LANE_W, clog2(NUM_LANES), lane index width (derived).

Ports:
- FAB_CLK  in  1  sole clock.
- ARST_N  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  controller can accept a command.
- CMD_OP  in  2  operation: 00 LOAD, 01 INC, 10 DEC, 11 SET.
- CMD_LANE  in  LANE_W  target lane.
- CMD_BCAST  in  1  apply the command to all lanes.
- CMD_VALUE  in  TAP_W  step count (INC/DEC) or target tap (SET).
- DONE  out  1  one-cycle completion pulse.
- CMD_ERR  out  1  status of the last command, valid while DONE is high.
- DELAY_LINE_LOAD  out  NUM_LANES  per-lane load pulse.
- DELAY_LINE_MOVE  out  NUM_LANES  per-lane move pulse.
- DELAY_LINE_DIRECTION  out  NUM_LANES  per-lane direction, 1 = increment.
- DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane IOD range flag.
- ERR_LANE  out  NUM_LANES  sticky per-lane error flags.
- ERR_CLR  in  1  clears ERR_LANE.
- RD_LANE  in  LANE_W  readback lane select.
- RD_TAP  out  TAP_W  registered tap count of RD_LANE.

Behaviour:
- Reset values:
  - All outputs are 0 except CMD_READY = 1.
  - All tracked tap counts = RESET_TAP.
  - State = IDLE.
  - Reset is asynchronous and abandons any command immediately; no pulses follow.
- Handshake:
  - CMD_READY = (state == IDLE).
  - A command is accepted on the FAB_CLK edge where CMD_VALID and CMD_READY are both high (call this edge k).
  - Command fields are captured at acceptance. Input changes after acceptance are ignored.
- Lane select mask:
  - CMD_BCAST = 1: all lanes.
  - Otherwise: lane CMD_LANE only.
  - CMD_LANE >= NUM_LANES with CMD_BCAST = 0: DONE with CMD_ERR = 1 at cycle k+1, no pulses.
- States: IDLE, LOAD, SETUP, MOVE, GAP, FIN.
- LOAD: DELAY_LINE_LOAD is high for masked lanes during cycle k+1. Their counts become RESET_TAP. DONE at k+2.
- INC/DEC:
  - Step count N = CMD_VALUE. N = 0 gives DONE at k+1 with no pulses.
  - SETUP at k+1: DIRECTION is driven for masked lanes and held until FIN.
  - MOVE: one-cycle pulse on masked lanes; tracked count changes by ±1.
  - GAP: MOVE_GAP cycles, then the next MOVE.
  - With G = MOVE_GAP, move j (0-based) is at cycle k+2+j*(G+1). DONE is at k+2+N*(G+1).
- SET:
  - Single lane: compute the difference D = CMD_VALUE minus the tracked count and behave as INC/DEC with |D| steps.
  - D = 0: DONE at k+1.
  - CMD_VALUE > MAX_TAP: error at k+1, no pulses.
  - SET with CMD_BCAST = 1 is illegal: CMD_ERR = 1 at k+1, no pulses.
- Range checks:
  - Before each MOVE: if any masked lane's count is at MAX_TAP (INC) or 0 (DEC), abort without pulsing.
  - On the last GAP cycle: a high DELAY_LINE_OUT_OF_RANGE on any masked lane aborts.
  - Abort goes to FIN next cycle with CMD_ERR = 1 and sets ERR_LANE for the offending lanes.
  - Counts retain the moves actually issued.
- ERR_LANE:
  - Sticky; cleared by ERR_CLR.
  - A set and a clear in the same cycle: set wins.
- DONE: high for exactly one cycle (FIN), then IDLE. CMD_READY returns high the cycle after DONE.
- RD_TAP:
  - Registered, one-cycle latency: tap[RD_LANE] as of the previous cycle.
  - RD_LANE out of range reads 0.
- DIRECTION:
  - Unmasked lanes hold their previous DIRECTION.
  - MOVE, LOAD and DIRECTION are never pulsed on unmasked lanes.

Test Plan:
- Reset, then read all lanes → RD_TAP = 1 for lanes 0..13; CMD_READY = 1; all pulse outputs 0.
- Lane 3 INC, VALUE = 3, MOVE_GAP = 4, accepted at k:
  - MOVE[3] high at k+2, k+7 and k+12; DIRECTION[3] = 1 from k+1; DONE at k+17.
  - RD_TAP(3) = 4; no other lane toggles.
- Broadcast DEC, VALUE = 2, from reset → first move takes all lanes to 0; second move is prechecked and aborted; DONE with CMD_ERR = 1; ERR_LANE = all ones; counts = 0.
- Lane 5 SET, VALUE = 10 → 9 increment moves; DONE at k+2+9*5 = k+47; RD_TAP(5) = 10. Then a broadcast SET → CMD_ERR = 1 at k+1, no pulses.
- Lane 2 INC, VALUE = 5, with OUT_OF_RANGE[2] forced high during the second GAP → exactly 2 moves issued; ERR_LANE[2] = 1; count = 3. ERR_CLR in the same cycle as a new error → bit stays 1.
- Assert ARST_N low mid-INC at move 2 → all pulses drop immediately; after release, counts = RESET_TAP and CMD_READY = 1.
